// File: rtl/sram_audio_streamer_pkg.sv
// Shared types and constants for the SRAM audio playback engine.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    DRAIN = 2'd3
  } play_state_t;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_READ = 2'd1,
    F_TURN = 2'd2
  } fetch_state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_NUM_CH = 2;

  typedef logic [DEF_NUM_CH-1:0][DEF_DATA_W-1:0] frame_t;

  // The SRAM is only ever read: chip and byte lanes stay enabled, WE_N stays high.
  localparam logic SRAM_CE_N_ON   = 1'b0;
  localparam logic SRAM_BE_N_ON   = 1'b0;
  localparam logic SRAM_OE_N_IDLE = 1'b1;
  localparam logic SRAM_WE_N_IDLE = 1'b1;

endpackage

// File: rtl/sram_audio_streamer_if.sv
// Async SRAM read bus: the streamer drives controls/address, the SRAM returns data.
interface sram_audio_streamer_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic              SRAM_CE_N;
  logic              SRAM_UB_N;
  logic              SRAM_LB_N;
  logic              SRAM_OE_N;
  logic              SRAM_WE_N;
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic [DATA_W-1:0] sram_rdata;

  modport master (
    output SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_OE_N, SRAM_WE_N, SRAM_ADDR,
    input  sram_rdata
  );

  modport slave (
    input  SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_OE_N, SRAM_WE_N, SRAM_ADDR,
    output sram_rdata
  );
endinterface

// File: rtl/sram_audio_streamer_frame_fifo.sv
// Synchronous frame FIFO; a pop frees its slot for a push in the same cycle.
module frame_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   Clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_idx_reg;
  logic [AW-1:0]    rd_idx_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = count_reg;
  assign rd_data = mem[rd_idx_reg];

  always_ff @(posedge Clk) begin
    if (do_push) begin
      mem[wr_idx_reg] <= wr_data;
    end
  end

  always_ff @(posedge Clk) begin
    if (!reset_n || flush) begin
      wr_idx_reg <= '0;
      rd_idx_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_idx_reg <= wr_idx_reg + AW'(1);
      if (do_pop)  rd_idx_reg <= rd_idx_reg + AW'(1);
      count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/sram_audio_streamer.sv
// SRAM-to-audio playback engine: fetches interleaved PCM frames into a FIFO
// and hands one frame to the audio driver per sample tick.
module sram_audio_streamer
  import audio_pkg::*;
#(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int RD_WAIT    = 2
) (
  input  logic                     Clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     cont,
  input  logic                     loop_en,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [ADDR_W-1:0]        end_addr,
  input  logic                     sample_tick,
  sram_audio_streamer_if.master    sram,
  output logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     frame_valid,
  output logic                     underrun,
  output logic [1:0]               state_o
);
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WAIT_W  = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int FRAME_W = NUM_CH * DATA_W;

  play_state_t       state_reg, state_next;
  fetch_state_t      fetch_reg, fetch_next;
  logic              start_d_reg, cont_d_reg, start_edge, cont_edge;
  logic [ADDR_W-1:0] base_reg, end_reg, rd_ptr_reg;
  logic [CH_W-1:0]   ch_idx_reg;
  logic [WAIT_W-1:0] wait_reg;
  logic              hit_reg, done_reg;
  logic [DATA_W-1:0] frame_reg [NUM_CH];
  logic [FRAME_W-1:0] frame_packed, fifo_rd_data, ch_data_reg;
  logic              frame_valid_reg, underrun_reg;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              pop, push, capture, last_word, word_at_end, frame_hit;
  logic              run_ok, room_after_push;

  assign start_edge  = start & ~start_d_reg;
  assign cont_edge   = cont & ~cont_d_reg;
  assign capture     = (fetch_reg == F_READ) && (wait_reg == WAIT_W'(RD_WAIT - 1));
  assign last_word   = (ch_idx_reg == CH_W'(NUM_CH - 1));
  assign push        = (fetch_reg == F_TURN) && last_word;
  // A reversed range degenerates to a single frame at base: every frame counts as the last.
  assign word_at_end = (rd_ptr_reg == end_reg) || (end_reg < base_reg);
  assign frame_hit   = hit_reg || word_at_end;
  assign run_ok      = (state_reg == PLAY) && !done_reg;
  assign pop         = sample_tick && ((state_reg == PLAY) || (state_reg == DRAIN))
                       && !fifo_empty && !start_edge;
  assign room_after_push = pop ? (fifo_count < CNT_W'(FIFO_DEPTH))
                               : (fifo_count < CNT_W'(FIFO_DEPTH - 1));

  assign sram.SRAM_CE_N = SRAM_CE_N_ON;
  assign sram.SRAM_UB_N = SRAM_BE_N_ON;
  assign sram.SRAM_LB_N = SRAM_BE_N_ON;
  assign sram.SRAM_WE_N = SRAM_WE_N_IDLE;
  assign sram.SRAM_OE_N = (fetch_reg == F_READ) ? ~SRAM_OE_N_IDLE : SRAM_OE_N_IDLE;
  assign sram.SRAM_ADDR = rd_ptr_reg;

  assign ch_data     = ch_data_reg;
  assign frame_valid = frame_valid_reg;
  assign underrun    = underrun_reg;
  assign state_o     = state_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_slot
      always_ff @(posedge Clk) begin
        if (capture && (ch_idx_reg == CH_W'(gi))) begin
          frame_reg[gi] <= sram.sram_rdata;
        end
      end
      assign frame_packed[gi*DATA_W +: DATA_W] = frame_reg[gi];
    end
  endgenerate

  frame_fifo #(.WIDTH(FRAME_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .Clk     (Clk),
    .reset_n (reset_n),
    .flush   (start_edge),
    .push    (push),
    .pop     (pop),
    .wr_data (frame_packed),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    state_next = state_reg;
    fetch_next = fetch_reg;
    if (start_edge) begin
      state_next = PLAY;
    end else begin
      case (state_reg)
        PLAY:    if (cont_edge) state_next = PAUSE;
                 else if (done_reg && fetch_reg == F_IDLE) state_next = DRAIN;
        PAUSE:   if (cont_edge) state_next = PLAY;
        DRAIN:   if (sample_tick && fifo_empty) state_next = IDLE;
        default: state_next = state_reg;
      endcase
    end
    // New frames begin only at frame boundaries, so a pause lets the current frame finish.
    case (fetch_reg)
      F_IDLE:  if (run_ok && !fifo_full) fetch_next = F_READ;
      F_READ:  if (capture) fetch_next = F_TURN;
      F_TURN:  if (!last_word) fetch_next = F_READ;
               else if (run_ok && !(frame_hit && !loop_en) && room_after_push) fetch_next = F_READ;
               else fetch_next = F_IDLE;
      default: fetch_next = F_IDLE;
    endcase
    if (start_edge) fetch_next = F_IDLE;
  end

  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      fetch_reg       <= F_IDLE;
      start_d_reg     <= 1'b0;
      cont_d_reg      <= 1'b0;
      base_reg        <= '0;
      end_reg         <= '0;
      rd_ptr_reg      <= '0;
      ch_idx_reg      <= '0;
      wait_reg        <= '0;
      hit_reg         <= 1'b0;
      done_reg        <= 1'b0;
      ch_data_reg     <= '0;
      frame_valid_reg <= 1'b0;
      underrun_reg    <= 1'b0;
    end else begin
      start_d_reg     <= start;
      cont_d_reg      <= cont;
      state_reg       <= state_next;
      fetch_reg       <= fetch_next;
      frame_valid_reg <= pop;

      if (pop) ch_data_reg <= fifo_rd_data;
      else if (state_reg == DRAIN && state_next == IDLE) ch_data_reg <= '0;

      if (start_edge) underrun_reg <= 1'b0;
      else if (sample_tick && state_reg == PLAY && fifo_empty) underrun_reg <= 1'b1;

      if (start_edge) begin
        base_reg   <= base_addr;
        end_reg    <= end_addr;
        rd_ptr_reg <= base_addr;
        ch_idx_reg <= '0;
        wait_reg   <= '0;
        hit_reg    <= 1'b0;
        done_reg   <= 1'b0;
      end else begin
        case (fetch_reg)
          F_READ: wait_reg <= capture ? '0 : wait_reg + WAIT_W'(1);
          F_TURN: begin
            if (last_word) begin
              ch_idx_reg <= '0;
              hit_reg    <= 1'b0;
              if (frame_hit && loop_en) begin
                rd_ptr_reg <= base_reg;
              end else begin
                rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
                if (frame_hit) done_reg <= 1'b1;
              end
            end else begin
              ch_idx_reg <= ch_idx_reg + CH_W'(1);
              rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
              if (word_at_end) hit_reg <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sram_audio_streamer.sv
// Self-checking bench: SRAM model returns word = address; frames checked via a scoreboard queue.
module tb_sram_audio_streamer;
  import audio_pkg::*;

  localparam int ADDR_W     = 20;
  localparam int DATA_W     = 16;
  localparam int NUM_CH     = 2;
  localparam int FIFO_DEPTH = 8;
  localparam int RD_WAIT    = 2;

  logic Clk = 1'b0;
  logic reset_n = 1'b0, start = 1'b0, cont = 1'b0, loop_en = 1'b0, sample_tick = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0, end_addr = '0;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic frame_valid, underrun;
  logic [1:0] state_o;

  sram_audio_streamer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) sif ();

  assign sif.sram_rdata = sif.SRAM_OE_N ? 16'hDEAD : sif.SRAM_ADDR[15:0];

  sram_audio_streamer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CH(NUM_CH),
    .FIFO_DEPTH(FIFO_DEPTH), .RD_WAIT(RD_WAIT)
  ) dut (
    .Clk         (Clk),
    .reset_n     (reset_n),
    .start       (start),
    .cont        (cont),
    .loop_en     (loop_en),
    .base_addr   (base_addr),
    .end_addr    (end_addr),
    .sample_tick (sample_tick),
    .sram        (sif),
    .ch_data     (ch_data),
    .frame_valid (frame_valid),
    .underrun    (underrun),
    .state_o     (state_o)
  );

  always #10 Clk = ~Clk;

  typedef struct {
    logic       expect_frame;
    frame_t     frame;
    logic [1:0] state_after;
    logic       underrun_after;
  } vec_t;

  int     n_checks = 0;
  int     n_pass   = 0;
  logic   sb_en    = 1'b1;
  frame_t exp_q[$];
  frame_t sb_exp;
  vec_t   vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic frame_t mk_frame(input int a);
    frame_t f;
    f[0] = 16'(a);
    f[1] = 16'(a + 1);
    return f;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic tick();
    @(posedge Clk); #1 sample_tick = 1'b1;
    @(posedge Clk); #1 sample_tick = 1'b0;
  endtask

  task automatic tick_exp(input frame_t f);
    exp_q.push_back(f);
    tick();
  endtask

  task automatic pulse_start(input int b, input int e, input logic l);
    base_addr = ADDR_W'(b);
    end_addr  = ADDR_W'(e);
    loop_en   = l;
    start     = 1'b1;
    wait_cycles(3);
    start     = 1'b0;
    wait_cycles(1);
  endtask

  task automatic pulse_cont();
    cont = 1'b1;
    wait_cycles(2);
    cont = 1'b0;
    wait_cycles(2);
  endtask

  // Scoreboard: every delivered frame must match the oldest expectation.
  always @(negedge Clk) begin
    if (reset_n && frame_valid && sb_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_frame: got %h, expected no frame", ch_data);
      end else begin
        sb_exp = exp_q.pop_front();
        $display("frame delivered %h (expected %h)", ch_data, sb_exp);
        check("frame", 64'(ch_data), 64'(sb_exp));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int waited;
    int seq;
    int n_del;

    vecs[0] = '{1'b1, mk_frame(16'h100), 2'd3, 1'b0};
    vecs[1] = '{1'b1, mk_frame(16'h102), 2'd3, 1'b0};
    vecs[2] = '{1'b1, mk_frame(16'h104), 2'd3, 1'b0};
    vecs[3] = '{1'b1, mk_frame(16'h106), 2'd3, 1'b0};
    vecs[4] = '{1'b0, '0,               2'd0, 1'b0};

    // Reset state
    wait_cycles(3);
    reset_n = 1'b1;
    wait_cycles(1);
    check("rst_state", 64'(state_o), 64'd0);
    check("rst_oe_n", 64'(sif.SRAM_OE_N), 64'd1);
    check("rst_we_n", 64'(sif.SRAM_WE_N), 64'd1);
    check("rst_ce_n", 64'(sif.SRAM_CE_N), 64'd0);
    check("rst_be_n", 64'({sif.SRAM_UB_N, sif.SRAM_LB_N}), 64'd0);
    check("rst_addr", 64'(sif.SRAM_ADDR), 64'd0);
    check("rst_ch_data", 64'(ch_data), 64'd0);
    check("rst_underrun", 64'(underrun), 64'd0);
    check("rst_valid", 64'(frame_valid), 64'd0);

    // One-shot clip 0x100..0x107 then drain to IDLE
    pulse_start(16'h100, 16'h107, 1'b0);
    check("play_state", 64'(state_o), 64'd1);
    wait_cycles(100);
    check("drain_state", 64'(state_o), 64'd3);
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].expect_frame) exp_q.push_back(vecs[i].frame);
      tick();
      wait_cycles(3);
      check("vec_state", 64'(state_o), 64'(vecs[i].state_after));
      check("vec_underrun", 64'(underrun), 64'(vecs[i].underrun_after));
      if (!vecs[i].expect_frame) check("vec_ch_data_cleared", 64'(ch_data), 64'd0);
    end

    // Looping clip, slow ticks: wraps after the 4th frame, never runs dry
    pulse_start(16'h100, 16'h107, 1'b1);
    wait_cycles(100);
    for (int k = 0; k < 10; k++) begin
      tick_exp(mk_frame(16'h100 + 2 * (k % 4)));
      wait_cycles(62);
    end
    check("loop_underrun", 64'(underrun), 64'd0);
    check("loop_state", 64'(state_o), 64'd1);

    // Fast ticks: underrun must latch and stay set until restart
    sb_en = 1'b0;
    pulse_start(16'h100, 16'h107, 1'b1);
    seq = 0;
    n_del = 0;
    for (int k = 0; k < FIFO_DEPTH + 2; k++) begin
      tick();
      @(negedge Clk);
      if (frame_valid) begin
        check("fast_frame_seq", 64'(ch_data), 64'(mk_frame(16'h100 + 2 * (seq % 4))));
        seq++;
        n_del++;
      end
      wait_cycles(2);
    end
    check("fast_underrun", 64'(underrun), 64'd1);
    check("fast_some_frames", 64'(n_del > 0), 64'd1);
    wait_cycles(50);
    check("underrun_sticky", 64'(underrun), 64'd1);
    pulse_start(16'h100, 16'h107, 1'b1);
    sb_en = 1'b1;
    check("underrun_cleared", 64'(underrun), 64'd0);

    // Pause / resume
    wait_cycles(100);
    tick_exp(mk_frame(16'h100));
    wait_cycles(3);
    tick_exp(mk_frame(16'h102));
    wait_cycles(3);
    pulse_cont();
    check("pause_state", 64'(state_o), 64'd2);
    for (int k = 0; k < 3; k++) begin
      tick();
      wait_cycles(3);
    end
    check("pause_ch_held", 64'(ch_data), 64'(mk_frame(16'h102)));
    check("pause_no_underrun", 64'(underrun), 64'd0);
    pulse_cont();
    check("resume_state", 64'(state_o), 64'd1);
    tick_exp(mk_frame(16'h104));
    wait_cycles(3);

    // Reset during an SRAM read
    waited = 0;
    while (sif.SRAM_OE_N !== 1'b0 && waited < 20) begin
      @(negedge Clk);
      waited++;
    end
    check("oe_low_seen", 64'(waited < 20), 64'd1);
    reset_n = 1'b0;
    @(posedge Clk); #1;
    check("midrst_oe_n", 64'(sif.SRAM_OE_N), 64'd1);
    check("midrst_state", 64'(state_o), 64'd0);
    check("midrst_fifo_count", 64'(dut.u_fifo.count), 64'd0);
    check("midrst_ch_data", 64'(ch_data), 64'd0);
    reset_n = 1'b1;
    wait_cycles(2);

    // Restart from DRAIN with a new clip at 0x200
    pulse_start(16'h100, 16'h107, 1'b0);
    wait_cycles(100);
    check("drain2_state", 64'(state_o), 64'd3);
    tick_exp(mk_frame(16'h100));
    wait_cycles(3);
    pulse_start(16'h200, 16'h207, 1'b0);
    check("restart_state", 64'(state_o), 64'd1);
    wait_cycles(100);
    check("drain3_state", 64'(state_o), 64'd3);
    for (int k = 0; k < 4; k++) begin
      tick_exp(mk_frame(16'h200 + 2 * k));
      wait_cycles(3);
    end
    tick();
    wait_cycles(3);
    check("final_idle", 64'(state_o), 64'd0);
    check("final_ch_data", 64'(ch_data), 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sram_audio_streamer.md
Name: sram_audio_streamer

Overview:
Parametrised SRAM-to-audio playback engine. Reads interleaved multi-channel PCM frames from the external async SRAM (read-only), buffers them in a small frame FIFO, and presents one frame per audio sample tick to the audio driver. Generalises the single-channel SRAM reading FSM with channel count, FIFO depth, wait states, loop/pause modes and underrun reporting.

Parameters:
ADDR_W, 20, SRAM word-address width
DATA_W, 16, sample/word width
NUM_CH, 2, channels per frame, stored as consecutive words (ch0 first)
FIFO_DEPTH, 8, frames buffered (power of two, >=2)
RD_WAIT, 2, cycles OE_N held low per word read (>=1); data sampled on last cycle

Ports:
Clk  in  1  system clock (50 MHz)
reset_n  in  1  synchronous active-low reset
start  in  1  level, debounced; rising edge starts/restarts playback
cont  in  1  level, debounced; rising edge toggles pause/resume
loop_en  in  1  1 = wrap to base_addr at end, 0 = stop at end
base_addr  in  ADDR_W  first word of clip; sampled on start edge
end_addr  in  ADDR_W  last word of clip (inclusive); sampled on start edge
sample_tick  in  1  one-cycle pulse per audio sample period
sram_rdata  in  DATA_W  SRAM_DQ read value (already through tristate)
SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_OE_N, SRAM_WE_N  out  1 each  SRAM controls
SRAM_ADDR  out  ADDR_W  SRAM word address
ch_data  out  NUM_CH*DATA_W  current frame, ch0 at LSBs
frame_valid  out  1  one-cycle pulse when ch_data updated
underrun  out  1  sticky: tick arrived with FIFO empty while PLAY
state_o  out  2  IDLE=0, PLAY=1, PAUSE=2, DRAIN=3

Behaviour:
- Reset (reset_n=0 at Clk edge): state IDLE, FIFO empty, ch_data=0, frame_valid=0, underrun=0, SRAM_CE_N=0, UB_N=LB_N=0, OE_N=1, WE_N=1 (constant; never written), SRAM_ADDR=0. Reset mid-read aborts it; no partial frame enters FIFO.
- start/cont edge-detected internally (one register each); a held level acts once.
- IDLE: start edge -> latch base/end, rd_ptr=base_addr, flush FIFO, clear underrun, -> PLAY. cont ignored.
- PLAY: fetcher runs; sample_tick pops. cont edge -> PAUSE. start edge -> restart (as from IDLE, same cycle). Fetch pointer passes end_addr with loop_en=0 -> DRAIN.
- PAUSE: fetcher finishes in-flight word/frame then halts; ticks ignored (no pop, no underrun, ch_data held). cont edge -> PLAY. start edge -> restart.
- DRAIN: no fetches; ticks pop; tick with FIFO empty -> IDLE, ch_data=0, no underrun. start edge -> restart.
- Fetcher: begins a frame only if FIFO has a free slot. Per word: SRAM_ADDR=rd_ptr, OE_N low RD_WAIT cycles, capture sram_rdata into channel slot on last cycle, OE_N high 1 cycle (turnaround), rd_ptr++. Frame cost NUM_CH*(RD_WAIT+1) cycles; push occurs the cycle after the last capture.
- Wrap: after reading end_addr, rd_ptr=base_addr if loop_en else fetch stops. If end_addr lands mid-frame, frame is still completed with continuing addresses (clip length must be multiple of NUM_CH; not checked). end_addr<base_addr: treated as single-frame clip at base_addr.
- Pop: on sample_tick in PLAY/DRAIN with FIFO non-empty, ch_data<=head frame, frame_valid=1 next cycle. Latency tick->ch_data = 1 cycle. Empty in PLAY: ch_data held, frame_valid=0, underrun<=1.
- Simultaneous push and pop with FIFO full: pop first, push allowed same cycle (count unchanged).
- Unsigned pointer/count arithmetic; FIFO count width clog2(FIFO_DEPTH)+1.

Decomposition:
- Package audio_pkg: state enum (IDLE/PLAY/PAUSE/DRAIN), frame_t packed array [NUM_CH][DATA_W] via parameter defaults, SRAM control idle constants.
- Sub-module frame_fifo (parametrised width/depth, synchronous, full/empty/count, same-cycle push+pop). FSM, edge detect and fetcher stay in top.

Test Plan:
- Reset then start, base=0x100, end=0x107, NUM_CH=2, loop_en=0, SRAM model word=addr -> ticks yield frames {0x101,0x100}..{0x107,0x106}, then IDLE on next tick, ch_data=0, underrun=0.
- Same clip, loop_en=1, 10 ticks spaced 64 cycles -> 5th frame is {0x101,0x100} again; FIFO never empty after fill.
- Ticks every 4 cycles (faster than 6-cycle frame fetch) -> underrun=1 within first FIFO_DEPTH+2 ticks, stays 1 until next start edge.
- cont pulse in PLAY -> state_o=2, ticks ignored, ch_data held; second cont pulse -> state_o=1, next tick delivers next sequential frame.
- Assert reset_n=0 mid-read (OE_N low) -> next cycle OE_N=1, state IDLE, FIFO count 0, ch_data=0.
- start edge during DRAIN with new base=0x200 -> FIFO flushed, first frame after fill is {0x201,0x200}.
